// File: rtl/score_bin_to_bcd_pkg.sv
// Shared definitions for the score binary-to-BCD converter: FSM states,
// the dash code used for out-of-range digits and the decimal range limit.
package score_bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Largest value representable in num_digits decimal digits (10^n - 1).
    function automatic logic [63:0] max_val(input int unsigned num_digits);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < num_digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/score_bin_to_bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/score_bin_to_bcd.sv
// Iterative shift-add-3 converter from binary score to packed BCD digits,
// with leading-zero blank mask and overflow flag; outputs change only on done.
module score_bin_to_bcd
    import score_bin_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH  = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    overflow
);

    localparam int unsigned SW = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = max_val(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);

    state_t                state, state_nxt;
    logic [BIN_WIDTH-1:0]  bin_shift;
    logic [SW-1:0]         scratch;
    logic [SW-1:0]         scratch_adj;
    logic [CW-1:0]         cnt;
    logic                  ovf_pending;
    logic                  last_shift;
    logic [NUM_DIGITS-1:0] blank_calc;
    logic                  all_zero;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    assign last_shift = (cnt == CW'(BIN_WIDTH - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin_shift   <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_shift   <= bin_value;
                        scratch     <= '0;
                        cnt         <= '0;
                        ovf_pending <= (64'(bin_value) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    // Top bit of the corrected scratch falls off; ovf_pending covers it.
                    scratch   <= {scratch_adj[SW-2:0], bin_shift[BIN_WIDTH-1]};
                    bin_shift <= bin_shift << 1;
                    cnt       <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        blank_calc = '0;
        all_zero   = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (scratch[4*i +: 4] == 4'd0);
            blank_calc[i] = all_zero;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done       <= 1'b0;
            digits     <= '0;
            blank_mask <= BLANK_RST;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FINISH) begin
                done     <= 1'b1;
                overflow <= ovf_pending;
                if (ovf_pending) begin
                    digits     <= {NUM_DIGITS{BCD_BLANK}};
                    blank_mask <= '0;
                end else begin
                    digits     <= scratch;
                    blank_mask <= blank_calc;
                end
            end
        end
    end

endmodule
